// File: rtl/axi_lite_reg_bank.sv
// Parametrised register bank behind axi_lite_slave's simple register port:
// R/W control regs, RO status, W1C interrupt status, interrupt enable, version.

module axi_lite_reg_bank_ctrl_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  wr_stb
);
  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= '0;
      wr_stb <= 1'b0;
    end else begin
      wr_stb <= wr_en;
      if (wr_en) q <= wr_data;
    end
  end
endmodule

module axi_lite_reg_bank #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 8,
  parameter logic [DATA_WIDTH-1:0] VERSION    = 32'h0001_0000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          i_reg_address,
  output logic                           o_reg_invalid_addr,
  input  logic                           i_reg_in_rdy,
  output logic                           o_reg_in_ack_stb,
  input  logic [DATA_WIDTH-1:0]          i_reg_in_data,
  input  logic                           i_reg_out_req,
  output logic                           o_reg_out_rdy_stb,
  output logic [DATA_WIDTH-1:0]          o_reg_out_data,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_ctrl,
  output logic [NUM_REGS-1:0]            o_ctrl_wr_stb,
  input  logic [DATA_WIDTH-1:0]          i_status,
  input  logic [DATA_WIDTH-1:0]          i_irq_set,
  output logic                           o_irq
);
  localparam int IDX_W = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {S_IDLE, S_RESP, S_WAIT} state_t;

  typedef struct packed {
    logic wr;
    logic rd;
    logic ctrl;
    logic status;
    logic isr;
    logic ier;
    logic version;
    logic valid;
  } req_t;

  state_t                               state_q, state_d;
  req_t                                 req;
  logic                                 accept;
  logic [IDX_W-1:0]                     idx;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  ctrl_q;
  logic [NUM_REGS-1:0]                  ctrl_stb;
  logic [DATA_WIDTH-1:0]                isr_q, ier_q, isr_clr, rd_data, rd_q;
  logic                                 ack_q, rdy_q, inv_q, irq_q;

  assign idx    = i_reg_address[ADDR_WIDTH-1:2];
  assign accept = (state_q == S_IDLE) && (i_reg_in_rdy || i_reg_out_req);

  // Writes win when both request lines are up in the same cycle.
  always_comb begin
    req         = '0;
    req.wr      = accept & i_reg_in_rdy;
    req.rd      = accept & ~i_reg_in_rdy & i_reg_out_req;
    req.ctrl    = idx <  IDX_W'(NUM_REGS);
    req.status  = idx == IDX_W'(NUM_REGS);
    req.isr     = idx == IDX_W'(NUM_REGS + 1);
    req.ier     = idx == IDX_W'(NUM_REGS + 2);
    req.version = idx == IDX_W'(NUM_REGS + 3);
    req.valid   = (i_reg_address[1:0] == 2'b00) &&
                  (idx <= IDX_W'(NUM_REGS + 3)) &&
                  !(i_reg_in_rdy && (idx == IDX_W'(NUM_REGS) || idx == IDX_W'(NUM_REGS + 3)));
  end

  genvar k;
  generate
    for (k = 0; k < NUM_REGS; k++) begin : g_ctrl
      axi_lite_reg_bank_ctrl_reg #(.DATA_WIDTH(DATA_WIDTH)) u_reg (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (req.wr & req.valid & req.ctrl & (idx == IDX_W'(k))),
        .wr_data (i_reg_in_data),
        .q       (ctrl_q[k]),
        .wr_stb  (ctrl_stb[k])
      );
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (req.ctrl && idx == IDX_W'(i)) rd_data = ctrl_q[i];
    if (req.status)  rd_data = i_status;
    if (req.isr)     rd_data = isr_q;
    if (req.ier)     rd_data = ier_q;
    if (req.version) rd_data = VERSION;
  end

  assign isr_clr = (req.wr & req.valid & req.isr) ? i_reg_in_data : '0;

  // Set is OR-ed after the clear so a coincident set survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      isr_q <= '0;
      ier_q <= '0;
      irq_q <= 1'b0;
      rd_q  <= '0;
      ack_q <= 1'b0;
      rdy_q <= 1'b0;
      inv_q <= 1'b0;
    end else begin
      isr_q <= (isr_q & ~isr_clr) | i_irq_set;
      if (req.wr && req.valid && req.ier) ier_q <= i_reg_in_data;
      irq_q <= |(isr_q & ier_q);
      if (req.rd) rd_q <= req.valid ? rd_data : '0;
      ack_q <= req.wr;
      rdy_q <= req.rd;
      inv_q <= (req.wr | req.rd) & ~req.valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // WAIT holds until both request lines drop so a level request is serviced once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RESP;
      S_RESP:  state_d = S_WAIT;
      S_WAIT:  if (!i_reg_in_rdy && !i_reg_out_req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Reset masks strobes combinationally so an in-flight response never escapes.
  assign o_reg_in_ack_stb   = ack_q & ~rst;
  assign o_reg_out_rdy_stb  = rdy_q & ~rst;
  assign o_reg_invalid_addr = inv_q & ~rst;
  assign o_ctrl_wr_stb      = ctrl_stb & {NUM_REGS{~rst}};
  assign o_reg_out_data     = rd_q;
  assign o_ctrl             = ctrl_q;
  assign o_irq              = irq_q;

endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Randomised + directed bench for axi_lite_reg_bank against an array-based register model.

module tb_axi_lite_reg_bank;
  localparam int NR = 8;
  localparam logic [31:0] VER = 32'h0001_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   i_reg_address;
  logic          o_reg_invalid_addr;
  logic          i_reg_in_rdy;
  logic          o_reg_in_ack_stb;
  logic [31:0]   i_reg_in_data;
  logic          i_reg_out_req;
  logic          o_reg_out_rdy_stb;
  logic [31:0]   o_reg_out_data;
  logic [NR*32-1:0] o_ctrl;
  logic [NR-1:0] o_ctrl_wr_stb;
  logic [31:0]   i_status;
  logic [31:0]   i_irq_set;
  logic          o_irq;

  axi_lite_reg_bank #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR), .VERSION(VER)) dut (
    .clk(clk), .rst(rst),
    .i_reg_address(i_reg_address), .o_reg_invalid_addr(o_reg_invalid_addr),
    .i_reg_in_rdy(i_reg_in_rdy), .o_reg_in_ack_stb(o_reg_in_ack_stb), .i_reg_in_data(i_reg_in_data),
    .i_reg_out_req(i_reg_out_req), .o_reg_out_rdy_stb(o_reg_out_rdy_stb), .o_reg_out_data(o_reg_out_data),
    .o_ctrl(o_ctrl), .o_ctrl_wr_stb(o_ctrl_wr_stb),
    .i_status(i_status), .i_irq_set(i_irq_set), .o_irq(o_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_ctrl [NR];
  logic [31:0] m_isr, m_ier, m_rd;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NR*32-1:0] m_ctrl_vec();
    logic [NR*32-1:0] v;
    for (int i = 0; i < NR; i++) v[i*32 +: 32] = m_ctrl[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NR; i++) m_ctrl[i] = '0;
    m_isr = '0; m_ier = '0; m_rd = '0;
  endtask

  // One complete request: drive, check response, check strobes drop, check irq.
  task automatic do_op(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] set);
    int unsigned idx;
    bit          valid;
    logic [NR-1:0] exp_stb;
    logic [31:0] stat;
    idx     = addr >> 2;
    stat    = $urandom;
    valid   = (addr[1:0] == 2'b00) && (idx <= NR + 3) && !(wr && (idx == NR || idx == NR + 3));
    exp_stb = '0;
    if (!wr) begin
      if (!valid)             m_rd = '0;
      else if (idx < NR)      m_rd = m_ctrl[idx];
      else if (idx == NR)     m_rd = stat;
      else if (idx == NR + 1) m_rd = m_isr;
      else if (idx == NR + 2) m_rd = m_ier;
      else                    m_rd = VER;
    end else if (valid) begin
      if (idx < NR) begin m_ctrl[idx] = data; exp_stb[idx] = 1'b1; end
      else if (idx == NR + 1) m_isr = m_isr & ~data;
      else if (idx == NR + 2) m_ier = data;
    end
    m_isr = m_isr | set;

    @(negedge clk);
    i_reg_address = addr; i_reg_in_data = data; i_status = stat; i_irq_set = set;
    i_reg_in_rdy = wr; i_reg_out_req = !wr;
    @(negedge clk);
    i_irq_set = '0; i_reg_in_rdy = 1'b0; i_reg_out_req = 1'b0;
    chk("ack", o_reg_in_ack_stb, wr);
    chk("rdy", o_reg_out_rdy_stb, !wr);
    chk("invalid", o_reg_invalid_addr, !valid);
    chk("wr_stb", o_ctrl_wr_stb, exp_stb);
    chk("ctrl", o_ctrl, m_ctrl_vec());
    chk("rd_data", o_reg_out_data, m_rd);
    @(negedge clk);
    chk("strobes_off", {o_reg_in_ack_stb, o_reg_out_rdy_stb, o_reg_invalid_addr, o_ctrl_wr_stb}, '0);
    @(negedge clk);
    chk("irq", o_irq, |(m_isr & m_ier));
  endtask

  task automatic pulse_irq(input logic [31:0] set);
    @(negedge clk); i_irq_set = set;
    @(negedge clk); i_irq_set = '0;
    m_isr = m_isr | set;
    @(negedge clk);
    chk("irq_pulse", o_irq, |(m_isr & m_ier));
  endtask

  initial begin
    int n_ack, n_stb, n_rdy;
    logic [31:0] d;
    rst = 1'b1; i_reg_address = '0; i_reg_in_rdy = 1'b0; i_reg_in_data = '0;
    i_reg_out_req = 1'b0; i_status = '0; i_irq_set = '0;
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ctrl", o_ctrl, '0);
    chk("rst_rd", o_reg_out_data, '0);
    chk("rst_strobes", {o_reg_in_ack_stb, o_reg_out_rdy_stb, o_reg_invalid_addr, o_ctrl_wr_stb}, '0);
    chk("rst_irq", o_irq, 1'b0);

    // Basic write/read
    do_op(1, 32'h4, 32'hDEADBEEF, 0);
    do_op(0, 32'h4, 0, 0);
    chk("ctrl1_slice", o_ctrl[63:32], 32'hDEADBEEF);

    // Level request held 5 cycles is serviced once
    d = $urandom;
    @(negedge clk); i_reg_address = 32'h8; i_reg_in_data = d; i_reg_in_rdy = 1'b1;
    n_ack = 0; n_stb = 0;
    repeat (5) begin
      @(negedge clk);
      n_ack += int'(o_reg_in_ack_stb);
      n_stb += int'(o_ctrl_wr_stb[2]);
    end
    i_reg_in_rdy = 1'b0;
    m_ctrl[2] = d;
    repeat (2) @(negedge clk);
    chk("hold_acks", n_ack, 1);
    chk("hold_stbs", n_stb, 1);
    chk("hold_ctrl", o_ctrl, m_ctrl_vec());

    // Invalid accesses
    do_op(1, 32'h20, 32'h1234_5678, 0);
    do_op(1, 32'h2, 32'h1111_1111, 0);
    do_op(1, 32'h40, 32'h2222_2222, 0);
    do_op(1, 32'h2C, 32'h3333_3333, 0);
    do_op(0, 32'h40, 0, 0);
    do_op(0, 32'h2C, 0, 0);
    do_op(0, 32'h20, 0, 0);

    // Interrupts: set wins over coincident W1C
    do_op(1, 32'h28, 32'h4, 0);
    pulse_irq(32'h5);
    do_op(0, 32'h24, 0, 0);
    do_op(1, 32'h24, 32'h4, 32'h4);
    do_op(0, 32'h24, 0, 0);
    do_op(1, 32'h24, 32'h4, 0);
    do_op(0, 32'h24, 0, 0);

    // Simultaneous write and read: write first, read only after re-assertion
    d = $urandom;
    @(negedge clk); i_reg_address = 32'hC; i_reg_in_data = d; i_reg_in_rdy = 1'b1; i_reg_out_req = 1'b1;
    @(negedge clk);
    m_ctrl[3] = d;
    chk("both_ack", o_reg_in_ack_stb, 1'b1);
    chk("both_no_rdy", o_reg_out_rdy_stb, 1'b0);
    chk("both_stb", o_ctrl_wr_stb, 8'h08);
    i_reg_in_rdy = 1'b0;
    n_rdy = 0;
    repeat (3) begin @(negedge clk); n_rdy += int'(o_reg_out_rdy_stb); end
    chk("read_held_off", n_rdy, 0);
    i_reg_out_req = 1'b0;
    repeat (2) @(negedge clk);
    i_reg_out_req = 1'b1;
    @(negedge clk);
    chk("late_rdy", o_reg_out_rdy_stb, 1'b1);
    chk("late_data", o_reg_out_data, d);
    m_rd = d;
    i_reg_out_req = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during RESP
    @(negedge clk); i_reg_address = 32'h10; i_reg_in_data = 32'hA5A5_A5A5; i_reg_in_rdy = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("rst_resp_ack", o_reg_in_ack_stb, 1'b0);
    chk("rst_resp_stb", o_ctrl_wr_stb, '0);
    @(negedge clk); i_reg_in_rdy = 1'b0;
    @(negedge clk); rst = 1'b0;
    m_reset();
    chk("rst_resp_ctrl", o_ctrl, '0);
    chk("rst_resp_irq", o_irq, 1'b0);
    do_op(1, 32'h10, 32'h0BAD_F00D, 0);
    do_op(0, 32'h10, 0, 0);

    // Randomised traffic
    for (int t = 0; t < 80; t++) begin
      logic [31:0] a, s;
      if ($urandom_range(0, 9) == 0) a = ($urandom_range(0, NR + 4) << 2) | $urandom_range(1, 3);
      else                           a = $urandom_range(0, NR + 5) << 2;
      s = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 7)) : 32'h0;
      do_op($urandom_range(0, 1) == 1, a, $urandom, s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_lite_reg_bank.md
# axi_lite_reg_bank

Parametrised user register bank that sits behind `axi_lite_slave`'s simple register interface and replaces hand-written per-design register decode. It provides NUM_REGS read/write control registers exported to user logic, a read-only status register, a sticky interrupt status register with write-1-to-clear, an interrupt enable register and a constant version register. Access rules are enforced per register class, and bad accesses are flagged back to the slave as invalid-address responses.

## Interface
- ADDR_WIDTH, 32, width of register address from the slave
- DATA_WIDTH, 32, register data width
- NUM_REGS, 8, number of R/W control registers (1..64)
- VERSION, 32'h0001_0000, value returned by the version register
- clk  input  1  system clock
- rst  input  1  reset; synchronous and active-high
- i_reg_address  input  ADDR_WIDTH  byte address of current request
- o_reg_invalid_addr  output  1  one-cycle pulse, coincident with ack/rdy strobe, on an invalid access
- i_reg_in_rdy  input  1  write request pending (level)
- o_reg_in_ack_stb  output  1  one-cycle write-done strobe
- i_reg_in_data  input  DATA_WIDTH  write data
- i_reg_out_req  input  1  read request pending (level)
- o_reg_out_rdy_stb  output  1  one-cycle read-data-valid strobe
- o_reg_out_data  output  DATA_WIDTH  read data, held until next read
- o_ctrl  output  NUM_REGS*DATA_WIDTH  control registers, reg k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- o_ctrl_wr_stb  output  NUM_REGS  one-cycle pulse on bit k when control reg k is written
- i_status  input  DATA_WIDTH  live status value
- i_irq_set  input  DATA_WIDTH  per-bit interrupt set pulses
- o_irq  output  1  |(ISR & IER), registered

## Operation
- Word index = i_reg_address >> 2. Map: index 0..NUM_REGS-1 = CTRL[k] (R/W). NUM_REGS = STATUS (RO). NUM_REGS+1 = ISR (R, W1C). NUM_REGS+2 = IER (R/W). NUM_REGS+3 = VERSION (RO).
- Invalid access: i_reg_address[1:0] != 0, index > NUM_REGS+3, or write to STATUS/VERSION. Invalid write changes no state and fires no o_ctrl_wr_stb. Invalid read returns 0. Both still strobe ack/rdy, with o_reg_invalid_addr=1.
- STATUS read returns i_status sampled on the accept cycle.
- ISR bit n is set on the cycle after i_irq_set[n]=1. A write clears every bit written as 1. Same-cycle set and clear on one bit: set wins.
- FSM states:
  - IDLE: on accept, go to RESP. Write has priority when i_reg_in_rdy and i_reg_out_req are both high.
  - RESP: one cycle; the strobe is high. Go to WAIT.
  - WAIT: hold until i_reg_in_rdy=0 and i_reg_out_req=0, then go to IDLE. This stops a single request from being serviced twice.
- Reset values:
  - All CTRL, ISR, IER = 0; o_reg_out_data = 0.
  - All strobes, o_reg_invalid_addr and o_irq = 0; FSM = IDLE.

## Timing
- Request seen in IDLE at edge N. Register update, o_reg_out_data and strobes all valid from edge N+1, for exactly one cycle.
- o_ctrl reflects the new value from edge N+1, coincident with o_ctrl_wr_stb.
- Minimum 3 cycles between accepted requests: IDLE, RESP, then at least one WAIT cycle.
- o_irq updates one cycle after ISR/IER change, i.e. two cycles after an i_irq_set pulse.
- rst asserted in any state: next edge forces reset values and IDLE, and any in-flight strobe is suppressed. The first request can be accepted on the first edge with rst=0.

## Test plan
- Write 0xDEADBEEF to addr 0x4 -> ack strobe 1 cycle later, o_ctrl[63:32]=0xDEADBEEF, o_ctrl_wr_stb=8'h02, invalid=0. Read addr 0x4 -> rdy strobe, o_reg_out_data=0xDEADBEEF.
- Hold i_reg_in_rdy high 5 cycles -> exactly one ack and one o_ctrl_wr_stb pulse.
- Write to STATUS (0x20, NUM_REGS=8), to 0x2 and to 0x40 -> each: ack with invalid=1, no state change. Read 0x40 -> data 0, invalid=1. Read 0x2C -> VERSION.
- i_irq_set=0x5 pulse with IER=0x4 -> ISR=0x5 and o_irq=1. Write 0x4 to ISR (0x24) on the same cycle as an i_irq_set=0x4 pulse -> ISR stays 0x5. Then write 0x4 -> ISR=0x1, o_irq=0.
- i_reg_in_rdy and i_reg_out_req rise together -> write serviced first; the read is serviced only after both drop and the read re-asserts.
- Assert rst during RESP -> no strobe, all CTRL = 0, and the next request completes normally.
